p32_mem_stage: RTL and testbench

//   Memory-access/writeback stage directly downstream of the p32 execution unit.

---
 rtl/p32_pkg.sv | 39 +++
 rtl/p32_mem_stage_if.sv | 34 +++
 rtl/p32_load_align.sv | 31 +++
 rtl/p32_mem_stage.sv | 148 ++++++++++++++
 tb/tb_p32_mem_stage.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p32_pkg.sv
// Shared p32 definitions: memory opcodes, mem-stage state encoding and opcode classification helpers.
// Used by the mem stage and the decode stage.
package p32_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // A store with no byte enables has nothing to write, so it is rejected like a misaligned access.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane,
                                           input logic [3:0] be);
        logic bad;
        bad = 1'b0;
        if ((op == OP_LH || op == OP_LHU) && lane[0]) bad = 1'b1;
        if (op == OP_LW && lane != 2'b00)               bad = 1'b1;
        if (is_store(op) && be == 4'b0000)              bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/p32_mem_stage_if.sv
// Execution-unit handoff, data-memory port and writeback bundle of the p32 mem stage.
// slave = the mem stage itself; master = its environment (execution unit, memory, register file).
interface p32_mem_stage_if;
    logic        exec_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] mdata_out;
    logic [3:0]  store_loc;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    modport slave (
        input  exec_valid, op, rd, result, mdata_out, store_loc, dmem_rdata, dmem_ack,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_rd, wb_data, err
    );

    modport master (
        output exec_valid, op, rd, result, mdata_out, store_loc, dmem_rdata, dmem_ack,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_valid, wb_rd, wb_data, err
    );
endinterface

// File: rtl/p32_load_align.sv
// Selects and sign/zero-extends the addressed byte or halfword of a load word.
// Combinational, zero latency; no backpressure.
module p32_load_align
    import p32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [5:0]  op,
    input  logic [1:0]  addr,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'd0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/p32_mem_stage.sv
// p32 memory/writeback stage: one dmem req/ack per load/store, load alignment, one wb beat per rd write.
// Latency: non-mem 1 cycle, load >= 2 cycles; in_ready low while a memory request is outstanding.
module p32_mem_stage
    import p32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           m_clock,
    input  logic           p_reset,
    p32_mem_stage_if.slave bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        lane_q, lane_d;
    logic              in_ready_q, in_ready_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [31:0]       dmem_addr_q, dmem_addr_d;
    logic [3:0]        dmem_be_q, dmem_be_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              err_q, err_d;
    logic              mem_op;
    logic [31:0]       load_data;

    p32_load_align u_align (
        .rdata (bus.dmem_rdata),
        .op    (op_q),
        .addr  (lane_q),
        .data  (load_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        rd_d         = rd_q;
        lane_d       = lane_q;
        in_ready_d   = in_ready_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        err_d        = 1'b0;
        mem_op       = is_load(bus.op) || is_store(bus.op);

        if (state_q == IDLE) begin
            if (bus.exec_valid && in_ready_q) begin
                if (!mem_op) begin
                    wb_valid_d = (bus.rd != 5'd0);
                    wb_rd_d    = bus.rd;
                    wb_data_d  = bus.result;
                end else if (is_misaligned(bus.op, bus.result[1:0], bus.store_loc)) begin
                    err_d = 1'b1;
                end else begin
                    state_d      = REQ;
                    in_ready_d   = 1'b0;
                    dmem_req_d   = 1'b1;
                    cnt_d        = '0;
                    op_d         = bus.op;
                    rd_d         = bus.rd;
                    lane_d       = bus.result[1:0];
                    dmem_we_d    = is_store(bus.op);
                    dmem_addr_d  = {bus.result[31:2], 2'b00};
                    dmem_be_d    = is_store(bus.op) ? bus.store_loc : 4'b1111;
                    dmem_wdata_d = is_store(bus.op) ? bus.mdata_out : 32'd0;
                end
            end
        // Ack is tested before the timeout so an ack on the last allowed cycle still completes.
        end else if (bus.dmem_ack) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
            dmem_req_d = 1'b0;
            cnt_d      = '0;
            if (is_load(op_q) && rd_q != 5'd0) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = load_data;
            end
        end else if (cnt_q == CNT_LAST) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
            dmem_req_d = 1'b0;
            cnt_d      = '0;
            err_d      = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            rd_q         <= '0;
            lane_q       <= '0;
            in_ready_q   <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            lane_q       <= lane_d;
            in_ready_q   <= in_ready_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_p32_mem_stage.sv
// Bench for p32_mem_stage: directed vectors plus randomized instructions scored against a transaction model.
module tb_p32_mem_stage;
    import p32_pkg::*;

    localparam int TMO = 4;

    logic m_clock;
    logic p_reset;
    int   vectors     = 0;
    int   miscompares = 0;

    p32_mem_stage_if bus ();

    p32_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    initial begin
        m_clock = 1'b0;
        forever #5 m_clock = ~m_clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
        $fatal(1, "watchdog expired");
    end

    // Everything observed during one instruction's window, counted in cycles after the accept edge.
    typedef struct packed {
        logic [3:0]  req_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        stable;
        logic [3:0]  rdy_low;
        logic [3:0]  wb_cnt;
        logic [3:0]  wb_cyc;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        wb_rdy;
        logic [3:0]  err_cnt;
        logic [3:0]  err_cyc;
        logic        err_rdy;
        logic        rdy_end;
    } obs_t;

    function automatic string fmt(input obs_t o);
        return $sformatf("req=%0d addr=%h be=%b we=%b wd=%h stable=%b rdylow=%0d wb=%0d@%0d rd=%0d data=%h wbrdy=%b err=%0d@%0d errrdy=%b rdy=%b",
                         o.req_cycles, o.addr, o.be, o.we, o.wdata, o.stable, o.rdy_low, o.wb_cnt,
                         o.wb_cyc, o.wb_rd, o.wb_data, o.wb_rdy, o.err_cnt, o.err_cyc, o.err_rdy, o.rdy_end);
    endfunction

    function automatic logic [31:0] ext_load(input logic [5:0] op, input logic [1:0] lane,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        case (op)
            OP_LB, OP_LBU: begin
                v = (rdata >> (8 * lane)) & 32'hFF;
                if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            OP_LH, OP_LHU: begin
                v = (rdata >> (16 * lane[1])) & 32'hFFFF;
                if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Transaction-level expectation; delay = REQ cycle index carrying the ack, -1 for no ack.
    function automatic obs_t model(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] res,
                                   input logic [31:0] md, input logic [3:0] sl, input int delay,
                                   input logic [31:0] rdata);
        obs_t e;
        bit   ld, st, bad, acked;
        e = '0;
        e.stable  = 1'b1;
        e.rdy_end = 1'b1;
        ld = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        st = op inside {OP_SB, OP_SH, OP_SW};
        if (!ld && !st) begin
            if (rd != 5'd0) begin
                e.wb_cnt = 4'd1; e.wb_cyc = 4'd1; e.wb_rd = rd; e.wb_data = res; e.wb_rdy = 1'b1;
            end
            return e;
        end
        bad = (st && sl == 4'd0) || (op == OP_LW && res[1:0] != 2'd0) ||
              ((op == OP_LH || op == OP_LHU) && res[0]);
        if (bad) begin
            e.err_cnt = 4'd1; e.err_cyc = 4'd1; e.err_rdy = 1'b1;
            return e;
        end
        acked        = (delay >= 0) && (delay < TMO);
        e.req_cycles = acked ? 4'(delay + 1) : 4'(TMO);
        e.rdy_low    = e.req_cycles;
        e.addr       = res & 32'hFFFF_FFFC;
        e.be         = st ? sl : 4'hF;
        e.we         = st;
        e.wdata      = st ? md : 32'd0;
        if (!acked) begin
            e.err_cnt = 4'd1; e.err_cyc = 4'(TMO + 1); e.err_rdy = 1'b1;
        end else if (ld && rd != 5'd0) begin
            e.wb_cnt = 4'd1; e.wb_cyc = 4'(delay + 2); e.wb_rd = rd;
            e.wb_data = ext_load(op, res[1:0], rdata); e.wb_rdy = 1'b1;
        end
        return e;
    endfunction

    // Drives one instruction, plays the memory side, and records what the stage did over 8 cycles.
    task automatic run(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] md, input logic [3:0] sl, input int delay,
                       input logic [31:0] rdata, output obs_t o);
        int         nreq;
        logic [68:0] snap;
        o = '0;
        o.stable = 1'b1;
        nreq = 0;
        snap = '0;
        @(negedge m_clock);
        bus.exec_valid = 1'b1; bus.op = op; bus.rd = rd;
        bus.result = res; bus.mdata_out = md; bus.store_loc = sl;
        @(posedge m_clock);
        #1;
        bus.exec_valid = 1'b0; bus.op = 6'($urandom); bus.rd = 5'($urandom);
        bus.result = $urandom; bus.mdata_out = $urandom; bus.store_loc = 4'($urandom);
        for (int c = 1; c <= 8; c++) begin
            @(negedge m_clock);
            if (!bus.in_ready) o.rdy_low = o.rdy_low + 4'd1;
            if (bus.dmem_req) begin
                nreq++;
                if (nreq == 1) begin
                    snap  = {bus.dmem_addr, bus.dmem_be, bus.dmem_we, bus.dmem_wdata};
                    o.addr = bus.dmem_addr; o.be = bus.dmem_be; o.we = bus.dmem_we;
                    o.wdata = bus.dmem_we ? bus.dmem_wdata : 32'd0;
                end else if ({bus.dmem_addr, bus.dmem_be, bus.dmem_we, bus.dmem_wdata} !== snap) begin
                    o.stable = 1'b0;
                end
            end
            if (bus.wb_valid) begin
                o.wb_cnt = o.wb_cnt + 4'd1;
                if (o.wb_cnt == 4'd1) begin
                    o.wb_cyc = 4'(c); o.wb_rd = bus.wb_rd; o.wb_data = bus.wb_data; o.wb_rdy = bus.in_ready;
                end
            end
            if (bus.err) begin
                o.err_cnt = o.err_cnt + 4'd1;
                if (o.err_cnt == 4'd1) begin
                    o.err_cyc = 4'(c); o.err_rdy = bus.in_ready;
                end
            end
            bus.dmem_ack   = bus.dmem_req && (nreq - 1 == delay);
            bus.dmem_rdata = bus.dmem_ack ? rdata : $urandom;
        end
        o.req_cycles = 4'(nreq);
        o.rdy_end    = bus.in_ready;
        bus.dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [109:0] got;
        p_reset = 1'b0;
        bus.exec_valid = 1'b0; bus.op = '0; bus.rd = '0; bus.result = '0;
        bus.mdata_out = '0; bus.store_loc = '0; bus.dmem_rdata = '0; bus.dmem_ack = 1'b0;
        repeat (2) @(negedge m_clock);
        for (int i = 0; i < 2; i++) begin
            got = {bus.in_ready, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata,
                   bus.wb_valid, bus.wb_rd, bus.wb_data, bus.err};
            vectors++;
            if (got !== {1'b1, 109'd0}) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got %h expected %h", i, got, {1'b1, 109'd0});
            end
            @(negedge m_clock);
            p_reset = 1'b1;
        end
    endtask

    task automatic test_lw();
        obs_t o, e;
        run(OP_LW, 5'd5, 32'h104, $urandom, 4'($urandom), 2, 32'hDEAD_BEEF, o);
        e = model(OP_LW, 5'd5, 32'h104, 32'd0, 4'd0, 2, 32'hDEAD_BEEF);
        vectors++;
        if ({o.addr, o.be, o.wb_cnt, o.wb_cyc, o.wb_rd, o.wb_data} !==
            {32'h104, 4'hF, 4'd1, 4'd4, 5'd5, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL lw_direct: got %s expected addr=104 be=1111 wb=1@4 rd=5 data=deadbeef", fmt(o));
        end
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL lw_model: got %s expected %s", fmt(o), fmt(e));
        end
        run(OP_LW, 5'd9, 32'h80, 32'd0, 4'd0, 0, 32'h0BAD_F00D, o);
        vectors++;
        if ({o.wb_cnt, o.wb_cyc, o.wb_data} !== {4'd1, 4'd2, 32'h0BAD_F00D}) begin
            miscompares++;
            $display("FAIL lw_min_latency: got %s expected wb=1@2 data=0badf00d", fmt(o));
        end
    endtask

    task automatic test_align();
        logic [5:0]  ops [3] = '{OP_LB, OP_LBU, OP_LH};
        logic [31:0] adr [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] exv [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011};
        logic [5:0]  lds [5] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        obs_t        o, e;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] res, rdata;
        int          dly;
        for (int i = 0; i < 3; i++) begin
            rd  = 5'($urandom_range(1, 31));
            dly = $urandom_range(0, TMO - 1);
            run(ops[i], rd, adr[i], $urandom, 4'($urandom), dly, 32'h8011_2233, o);
            vectors++;
            if ({o.wb_cnt, o.wb_data} !== {4'd1, exv[i]}) begin
                miscompares++;
                $display("FAIL align_direct[%0d]: got wb=%0d data=%h expected wb=1 data=%h", i, o.wb_cnt, o.wb_data, exv[i]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            op    = lds[$urandom_range(0, 4)];
            rd    = 5'($urandom_range(0, 31));
            res   = $urandom;
            rdata = $urandom;
            dly   = $urandom_range(0, TMO - 1);
            run(op, rd, res, 32'd0, 4'd0, dly, rdata, o);
            e = model(op, rd, res, 32'd0, 4'd0, dly, rdata);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL align_random[%0d] op=%h res=%h: got %s expected %s", i, op, res, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_store();
        logic [5:0]  sts [3] = '{OP_SB, OP_SH, OP_SW};
        obs_t        o, e;
        logic [5:0]  op;
        logic [31:0] res, md;
        logic [3:0]  sl;
        int          dly;
        run(OP_SH, 5'd7, 32'h202, 32'hABCD_0000, 4'b1100, 1, $urandom, o);
        vectors++;
        if ({o.we, o.addr, o.be, o.wdata, o.wb_cnt, o.req_cycles} !==
            {1'b1, 32'h200, 4'b1100, 32'hABCD_0000, 4'd0, 4'd2}) begin
            miscompares++;
            $display("FAIL store_direct: got %s expected we=1 addr=200 be=1100 wd=abcd0000 wb=0 req=2", fmt(o));
        end
        for (int i = 0; i < 8; i++) begin
            op  = sts[$urandom_range(0, 2)];
            res = $urandom;
            md  = $urandom;
            sl  = 4'($urandom_range(1, 15));
            dly = $urandom_range(0, TMO - 1);
            run(op, 5'($urandom), res, md, sl, dly, $urandom, o);
            e = model(op, 5'd1, res, md, sl, dly, 32'd0);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL store_random[%0d]: got %s expected %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_misaligned();
        logic [5:0]  ops [4] = '{OP_LW, OP_LHU, OP_SW, OP_LH};
        logic [31:0] adr [4] = '{32'h102, 32'h103, 32'h100, 32'h105};
        obs_t        o, e;
        run(OP_LH, 5'd4, 32'h101, 32'd0, 4'd0, 0, $urandom, o);
        vectors++;
        if ({o.err_cnt, o.err_cyc, o.req_cycles, o.rdy_low, o.wb_cnt} !== {4'd1, 4'd1, 4'd0, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL misaligned_lh: got %s expected err=1@1 req=0 rdylow=0 wb=0", fmt(o));
        end
        for (int i = 0; i < 4; i++) begin
            run(ops[i], 5'd6, adr[i], $urandom, 4'd0, 0, $urandom, o);
            e = model(ops[i], 5'd6, adr[i], 32'd0, 4'd0, 0, 32'd0);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL misaligned[%0d]: got %s expected %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_timeout();
        int   dl [3] = '{-1, TMO - 1, TMO};
        obs_t o, e;
        run(OP_LW, 5'd8, 32'h40, 32'd0, 4'd0, -1, $urandom, o);
        vectors++;
        if ({o.req_cycles, o.err_cnt, o.err_cyc, o.err_rdy, o.wb_cnt} !== {4'd4, 4'd1, 4'd5, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL timeout_direct: got %s expected req=4 err=1@5 errrdy=1 wb=0", fmt(o));
        end
        for (int i = 0; i < 3; i++) begin
            run(OP_LBU, 5'd12, 32'h41, 32'd0, 4'd0, dl[i], 32'h1234_5678, o);
            e = model(OP_LBU, 5'd12, 32'h41, 32'd0, 4'd0, dl[i], 32'h1234_5678);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL timeout_delay[%0d]: got %s expected %s", dl[i], fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds [3] = '{5'd3, 5'd3, 5'd0};
        logic [31:0] res [3] = '{32'h1234_5678, 32'h1234_5678, 32'hCAFE_F00D};
        logic [5:0]  nmo [4] = '{6'h00, 6'h08, 6'h22, 6'h3F};
        logic [38:0] got, exp;
        for (int i = 0; i <= 3; i++) begin
            @(negedge m_clock);
            if (i > 0) begin
                got = {bus.wb_valid, bus.in_ready, bus.wb_valid ? {bus.wb_rd, bus.wb_data} : 37'd0};
                exp = {rds[i-1] != 5'd0, 1'b1, (rds[i-1] != 5'd0) ? {rds[i-1], res[i-1]} : 37'd0};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL back_to_back[%0d]: got %h expected %h", i - 1, got, exp);
                end
            end
            if (i < 3) begin
                bus.exec_valid = 1'b1; bus.op = nmo[$urandom_range(0, 3)];
                bus.rd = rds[i]; bus.result = res[i];
            end else begin
                bus.exec_valid = 1'b0;
            end
        end
        @(negedge m_clock);
        vectors++;
        if (bus.wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_idle: got wb_valid=%b expected 0", bus.wb_valid);
        end
    endtask

    task automatic test_idle_ack();
        for (int i = 0; i < 3; i++) begin
            @(negedge m_clock);
            bus.dmem_ack = 1'b1; bus.dmem_rdata = $urandom;
            @(negedge m_clock);
            bus.dmem_ack = 1'b0;
            vectors++;
            if ({bus.dmem_req, bus.wb_valid, bus.err, bus.in_ready} !== 4'b0001) begin
                miscompares++;
                $display("FAIL idle_ack[%0d]: got req/wb/err/rdy=%b expected 0001", i,
                         {bus.dmem_req, bus.wb_valid, bus.err, bus.in_ready});
            end
        end
    endtask

    task automatic test_reset_mid_req();
        @(negedge m_clock);
        bus.exec_valid = 1'b1; bus.op = OP_LW; bus.rd = 5'd2; bus.result = 32'h300;
        @(posedge m_clock);
        #1 bus.exec_valid = 1'b0;
        @(negedge m_clock);
        vectors++;
        if (bus.dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_req_pre: got dmem_req=%b expected 1", bus.dmem_req);
        end
        #2 p_reset = 1'b0;
        #1;
        vectors++;
        if ({bus.dmem_req, bus.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_req_async: got req/rdy=%b expected 01", {bus.dmem_req, bus.in_ready});
        end
        @(negedge m_clock);
        p_reset = 1'b1;
        repeat (2) @(negedge m_clock);
        vectors++;
        if ({bus.dmem_req, bus.in_ready, bus.err, bus.wb_valid} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset_mid_req_after: got req/rdy/err/wb=%b expected 0100",
                     {bus.dmem_req, bus.in_ready, bus.err, bus.wb_valid});
        end
    endtask

    task automatic test_random_mix();
        logic [5:0]  ops [13] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
                                  6'h00, 6'h22, 6'h2A, 6'h0F, 6'h3F};
        obs_t        o, e;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] res, md, rdata;
        logic [3:0]  sl;
        int          dly;
        for (int i = 0; i < 30; i++) begin
            op    = ops[$urandom_range(0, 12)];
            rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            res   = $urandom;
            md    = $urandom;
            sl    = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            rdata = $urandom;
            dly   = $urandom_range(0, 6);
            if (dly == 6) dly = -1;
            run(op, rd, res, md, sl, dly, rdata, o);
            e = model(op, rd, res, md, sl, dly, rdata);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL random_mix[%0d] op=%h rd=%0d res=%h sl=%b dly=%0d: got %s expected %s",
                         i, op, rd, res, sl, dly, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_align();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_idle_ack();
        test_reset_mid_req();
        test_random_mix();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
